instr_fetch: RTL

- Producer end of the decoder's instruction interface. Holds the PC and fetches 32-bit words from instruction memory over a valid/ready request/response port.
- Presents each fetched instruction, with its OP and Funct fields split out, to the decode stage through a valid/ready handshake.
- Accepts branch/jump redirects from downstream and flushes any fetch that is in flight.
- Non-pipelined: at most one memory request is outstanding at any time.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/instr_fetch.sv | 114 +++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, instruction
// field positions and the decoder control bundle.
package mips_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_DROP,
    FS_HOLD
  } fetch_state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } control_sig_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: holds the PC, issues one memory request at a time and
// presents each fetched word to decode over a valid/ready handshake.
// Downstream redirects flush the held instruction and any fetch in flight.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [5:0]          op,
  output logic [5:0]          funct,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [ADDR_W-1:0]   pc_plus4,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_t        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]   pc_plus4_q, pc_plus4_d;
  logic [ADDR_W-1:0]   redir_pc;

  assign redir_pc       = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign imem_req_valid = (state_q == FS_REQ);
  assign imem_req_addr  = pc_q;
  // A transfer can never complete in a redirect cycle.
  assign instr_valid    = (state_q == FS_HOLD) && !redirect_valid;
  assign instr          = instr_q;
  assign op             = instr_q[OP_MSB:OP_LSB];
  assign funct          = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign instr_pc       = instr_pc_q;
  assign pc_plus4       = pc_plus4_q;

  // State, PC and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
      pc_plus4_q <= RESET_PC + STEP;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  // Next-state, next-PC and instruction capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_plus4_d = pc_plus4_q;
    unique case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ: begin
        if (redirect_valid) pc_d = redir_pc;
        if (imem_req_ready) begin
          req_pc_d = pc_q;
          state_d  = redirect_valid ? FS_DROP : FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = imem_rsp_valid ? FS_REQ : FS_DROP;
        end else if (imem_rsp_valid) begin
          instr_d    = imem_rsp_data;
          instr_pc_d = req_pc_q;
          pc_plus4_d = req_pc_q + STEP;
          pc_d       = req_pc_q + STEP;
          state_d    = FS_HOLD;
        end
      end
      FS_DROP: begin
        if (redirect_valid) pc_d = redir_pc;
        if (imem_rsp_valid) state_d = FS_REQ;
      end
      FS_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = FS_REQ;
        end else if (instr_ready) begin
          state_d = FS_REQ;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

endmodule
